load_align_unit: RTL
====================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, bus/register width in bits; legal values 32 and 64.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req_valid  input  1  load request valid.
REQ-005 SHALL have port o_req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port i_addr  input  XLEN  byte address of load.
REQ-007 SHALL have port i_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-008 SHALL have port i_signext  input  1  1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port o_mem_req  output  1  memory read request.
REQ-010 SHALL have port o_mem_addr  output  XLEN  aligned memory address.
REQ-011 SHALL have port i_mem_ack  input  1  read data valid this cycle.
REQ-012 SHALL have port i_mem_rdata  input  XLEN  memory read data.
REQ-013 SHALL have port o_rsp_valid  output  1  result valid.
REQ-014 SHALL have port i_rsp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port o_rsp_data  output  XLEN  aligned, extended load result.
REQ-016 SHALL have port o_misalign_err  output  1  misaligned access rejected (config-dependent).

Function
REQ-017 SHALL implement FSM states IDLE, RD0, RD1, RESP; o_req_ready = 1 only in IDLE.
REQ-018 SHALL capture addr, size and signext on i_req_valid && o_req_ready, then enter RD0.
REQ-019 SHALL set bytes = 1/2/4/8 per i_size; i_size=11 with XLEN=32 SHALL be treated as word.
REQ-020 SHALL set offset = addr mod (XLEN/8); an access is misaligned when offset+bytes > XLEN/8.
REQ-021 SHALL drive o_mem_req=1 in RD0/RD1 and hold o_mem_addr stable until i_mem_ack.
REQ-022 SHALL set o_mem_addr in RD0 = addr with low log2(XLEN/8) bits cleared.
REQ-023 SHALL set o_mem_addr in RD1 = RD0 address + XLEN/8, modulo 2^XLEN (wraps to 0 at the top of the address space).
REQ-024 SHALL, on ack in RD0, go to RESP if aligned and to RD1 if misaligned; on ack in RD1, go to RESP.
REQ-025 SHALL form the result as ({rd1_data, rd0_data} >> 8*offset), take the low bytes*8 bits, then sign- or zero-extend to XLEN.
REQ-026 SHALL register o_rsp_data; o_rsp_valid=1 in RESP, held with data stable until i_rsp_ready, then return to IDLE.
REQ-027 SHALL give a latency of exactly 1 cycle from the final ack to o_rsp_valid; a response and a new request SHALL NOT overlap (new accept no earlier than the cycle after rsp handshake).
REQ-028 SHALL ignore i_mem_ack outside RD0/RD1.

Reset
REQ-029 SHALL, when i_rst=1 at a clock edge, force IDLE and clear all outputs and internal registers, with o_req_ready=1 next cycle.
REQ-030 SHALL let reset mid-transaction abandon it: no response, and a late i_mem_ack is ignored.

Configuration
REQ-031 SHALL support macro LOAD_ALIGN_MISALIGN_SPLIT_EN.
REQ-032 With LOAD_ALIGN_MISALIGN_SPLIT_EN defined, misaligned loads SHALL be split across RD0/RD1 per REQ-024; o_misalign_err is tied 0.
REQ-033 Without the macro, RD1 SHALL be absent; a misaligned request SHALL issue no memory read and SHALL go to RESP with o_rsp_data=0 and o_misalign_err=1 for the duration of o_rsp_valid.

Verification
REQ-034 XLEN=32, lw addr 0x100, rdata 0xDEADBEEF -> one read at 0x100, rsp 0xDEADBEEF one cycle after ack.
REQ-035 XLEN=32, lb signed addr 0x103, rdata 0x80FF00FF -> rsp 0xFFFFFF80; lbu -> 0x00000080.
REQ-036 XLEN=32, SPLIT_EN, lh signed addr 0x103, rdata 0x11223344 then 0x556677AA -> reads 0x100, 0x104; rsp 0xFFFFAA11.
REQ-037 XLEN=32, SPLIT_EN, lw addr 0xFFFFFFFE -> reads 0xFFFFFFFC then 0x00000000 (wrap).
REQ-038 Without the macro, lw addr 0x102 -> no o_mem_req, o_rsp_valid=1, o_misalign_err=1, data 0.
REQ-039 XLEN=64, ld addr 0x10 with i_rsp_ready held low 5 cycles -> o_rsp_valid and data held stable; i_rst asserted in RD0 -> IDLE, no response.

Source files
------------

// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two aligned words and extracts a sized,
// sign/zero-extended result. Macro LOAD_ALIGN_MISALIGN_SPLIT_EN enables split reads.
module load_align_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_addr,
  input  logic [1:0]      i_size,
  input  logic            i_signext,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_misalign_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid-side payload is held stable until that edge.
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD0, RESP} state_t;
`endif

  function automatic logic [3:0] f_bytes(input logic [1:0] size);
    case (size)
      2'b00:   f_bytes = 4'd1;
      2'b01:   f_bytes = 4'd2;
      2'b10:   f_bytes = 4'd4;
      default: f_bytes = (XLEN == 64) ? 4'd8 : 4'd4;
    endcase
  endfunction

  function automatic logic f_mis(input logic [OFFW-1:0] off, input logic [3:0] nbytes);
    f_mis = (5'(off) + 5'(nbytes)) > 5'(NB);
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_addr;
  logic [3:0]        r_bytes;
  logic              r_signext;
  logic [XLEN-1:0]   r_rsp_data;

  logic              w_accept;
  logic [OFFW-1:0]   w_offset;
  logic [XLEN-1:0]   w_base;
  logic [2*XLEN-1:0] w_pair;
  logic [XLEN-1:0]   w_raw;
  logic [6:0]        w_nbits;
  logic [XLEN-1:0]   w_mask;
  logic              w_sign;
  logic [XLEN-1:0]   w_result;

`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   r_rd0_data;
  logic              w_mis;
  assign w_mis  = f_mis(w_offset, r_bytes);
  assign w_pair = (r_state == RD1) ? {i_mem_rdata, r_rd0_data} : {{XLEN{1'b0}}, i_mem_rdata};
  assign o_misalign_err = 1'b0;
`else
  logic              r_err;
  logic              w_req_mis;
  assign w_req_mis = f_mis(i_addr[OFFW-1:0], f_bytes(i_size));
  assign w_pair    = {{XLEN{1'b0}}, i_mem_rdata};
  assign o_misalign_err = r_err;
`endif

  assign w_accept = i_req_valid && (r_state == IDLE);
  assign w_offset = r_addr[OFFW-1:0];
  assign w_base   = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Mask covers the low bytes*8 bits; its MSB locates the sign bit.
  assign w_raw    = XLEN'(w_pair >> {w_offset, 3'b000});
  assign w_nbits  = {r_bytes, 3'b000};
  assign w_mask   = (XLEN'(1) << w_nbits) - XLEN'(1);
  assign w_sign   = r_signext && |(w_raw & (w_mask ^ (w_mask >> 1)));
  assign w_result = (w_raw & w_mask) | (w_sign ? ~w_mask : {XLEN{1'b0}});

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = {XLEN{1'b0}};
    o_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
        if (w_accept) w_next = RD0;
`else
        if (w_accept) w_next = w_req_mis ? RESP : RD0;
`endif
      end
      RD0: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_base;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
        if (i_mem_ack) w_next = w_mis ? RD1 : RESP;
`else
        if (i_mem_ack) w_next = RESP;
`endif
      end
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      RD1: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_base + XLEN'(NB);
        if (i_mem_ack) w_next = RESP;
      end
`endif
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= {XLEN{1'b0}};
      r_bytes    <= 4'd0;
      r_signext  <= 1'b0;
      r_rsp_data <= {XLEN{1'b0}};
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      r_rd0_data <= {XLEN{1'b0}};
`else
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_addr    <= i_addr;
          r_bytes   <= f_bytes(i_size);
          r_signext <= i_signext;
`ifndef LOAD_ALIGN_MISALIGN_SPLIT_EN
          if (w_req_mis) begin
            r_rsp_data <= {XLEN{1'b0}};
            r_err      <= 1'b1;
          end
`endif
        end
        RD0: if (i_mem_ack) begin
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
          if (w_mis) r_rd0_data <= i_mem_rdata;
          else       r_rsp_data <= w_result;
`else
          r_rsp_data <= w_result;
`endif
        end
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
        RD1: if (i_mem_ack) r_rsp_data <= w_result;
`endif
        RESP: begin
`ifndef LOAD_ALIGN_MISALIGN_SPLIT_EN
          if (i_rsp_ready) r_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_data = r_rsp_data;

endmodule
